input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/retro_pkg.sv | 15 +
 rtl/debounce_channel.sv | 77 +++++++
 rtl/input_conditioner_chk.sv | 30 +++
 rtl/input_conditioner.sv | 93 +++++++++
 tb/tb_input_conditioner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/retro_pkg.sv
// Shared constants for the retro vending front end: debounce default and
// the channel numbering used to index the per-input conditioner lanes.
package retro_pkg;

    // Default number of clk cycles a synchronized level must persist.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Channel indices into the conditioner lane vectors.
    localparam int CH_COIN10  = 0;
    localparam int CH_COIN25  = 1;
    localparam int CH_NEXT    = 2;
    localparam int CH_SELECT  = 3;
    localparam int NUM_CH     = 4;

endpackage : retro_pkg

// File: rtl/debounce_channel.sv
// One conditioner lane: two-flop synchronizer, counter-based debounce of the
// synchronized level, and an arm flag so that a switch already high when the
// block comes out of reset never produces an event.
module debounce_channel
    import retro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o,
    output logic stable_o
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          armed_q;
    logic          armed_d;
    // primed_q[1] is set once sync2_q holds a real sample rather than its
    // reset value; the arm flag only trusts the synchronizer after that.
    logic [1:0]    primed_q;
    logic [1:0]    primed_d;
    logic          accept_s;

    // Debounce counter, acceptance of a new level, and arm/prime tracking.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            stable_d = sync2_q;
            cnt_d    = CNT_ZERO;
            accept_s = 1'b1;
        end
        primed_d = {primed_q[0], 1'b1};
        armed_d  = armed_q | (primed_q[1] & ~sync2_q & ~stable_q);
    end

    // Synchronizer, debounce and arm state, all cleared by the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
            armed_q  <= 1'b0;
            primed_q <= 2'b00;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            primed_q <= primed_d;
        end
    end

    // Rise event is flagged on the edge that accepts a new high level, so the
    // registered pulse in the parent lands on that same edge.
    assign rise_o   = accept_s & sync2_q & armed_q;
    assign stable_o = stable_q;

endmodule : debounce_channel

// File: rtl/input_conditioner_chk.sv
// Invariant checks on the conditioner outputs: one pulse per group per cycle,
// and a pulse only while its channel's accepted level is high.
module input_conditioner_chk
    import retro_pkg::*;
(
    input logic              clk,
    input logic              reset,
    input logic [NUM_CH-1:0] stable_i,
    input logic [NUM_CH-1:0] pulse_i
);

    a_one_coin : assert property (@(posedge clk) disable iff (reset)
        !(pulse_i[CH_COIN10] && pulse_i[CH_COIN25]));

    a_one_button : assert property (@(posedge clk) disable iff (reset)
        !(pulse_i[CH_NEXT] && pulse_i[CH_SELECT]));

    a_c10_level : assert property (@(posedge clk) disable iff (reset)
        pulse_i[CH_COIN10] |-> stable_i[CH_COIN10]);

    a_c25_level : assert property (@(posedge clk) disable iff (reset)
        pulse_i[CH_COIN25] |-> stable_i[CH_COIN25]);

    a_next_level : assert property (@(posedge clk) disable iff (reset)
        pulse_i[CH_NEXT] |-> stable_i[CH_NEXT]);

    a_sel_level : assert property (@(posedge clk) disable iff (reset)
        pulse_i[CH_SELECT] |-> stable_i[CH_SELECT]);

endmodule : input_conditioner_chk

// File: rtl/input_conditioner.sv
// Front-end conditioner for the vending FSM: four debounced lanes, coin and
// button arbitration, and registered single-cycle event pulses.
module input_conditioner
    import retro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_10,
    input  logic coin_25,
    input  logic next_item,
    input  logic select,
    output logic coin_10_p,
    output logic coin_25_p,
    output logic next_item_p,
    output logic select_p
);

    logic [NUM_CH-1:0] raw_s;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] stable_s;
    logic [NUM_CH-1:0] pulse_s;

    logic coin_10_p_q, coin_10_p_d;
    logic coin_25_p_q, coin_25_p_d;
    logic next_p_q,    next_p_d;
    logic select_p_q,  select_p_d;
    // A coin_10 event that lost arbitration to coin_25 in the same cycle.
    logic pend_q,      pend_d;

    assign raw_s[CH_COIN10] = coin_10;
    assign raw_s[CH_COIN25] = coin_25;
    assign raw_s[CH_NEXT]   = next_item;
    assign raw_s[CH_SELECT] = select;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (raw_s[g]),
            .rise_o   (rise_s[g]),
            .stable_o (stable_s[g])
        );
    end

    // Arbitration: coin_25 wins and coin_10 is deferred one cycle (never
    // dropped); select wins and a simultaneous next_item is discarded.
    always_comb begin
        coin_25_p_d = rise_s[CH_COIN25];
        pend_d      = rise_s[CH_COIN10] & rise_s[CH_COIN25];
        coin_10_p_d = pend_q | (rise_s[CH_COIN10] & ~rise_s[CH_COIN25]);
        select_p_d  = rise_s[CH_SELECT];
        next_p_d    = rise_s[CH_NEXT] & ~rise_s[CH_SELECT];
    end

    // Output pulse registers and the deferred coin_10 flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_10_p_q <= 1'b0;
            coin_25_p_q <= 1'b0;
            next_p_q    <= 1'b0;
            select_p_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            coin_10_p_q <= coin_10_p_d;
            coin_25_p_q <= coin_25_p_d;
            next_p_q    <= next_p_d;
            select_p_q  <= select_p_d;
            pend_q      <= pend_d;
        end
    end

    assign coin_10_p   = coin_10_p_q;
    assign coin_25_p   = coin_25_p_q;
    assign next_item_p = next_p_q;
    assign select_p    = select_p_q;

    assign pulse_s[CH_COIN10] = coin_10_p_q;
    assign pulse_s[CH_COIN25] = coin_25_p_q;
    assign pulse_s[CH_NEXT]   = next_p_q;
    assign pulse_s[CH_SELECT] = select_p_q;

    input_conditioner_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .stable_i (stable_s),
        .pulse_i  (pulse_s)
    );

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Vector bit order for both inputs and outputs: {coin_10, coin_25, next_item, select}.
module tb_input_conditioner;

    localparam int DC = 4;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] C10  = 4'b1000;
    localparam logic [3:0] C25  = 4'b0100;
    localparam logic [3:0] NXT  = 4'b0010;
    localparam logic [3:0] SEL  = 4'b0001;

    logic clk = 1'b0;
    logic reset;
    logic coin_10, coin_25, next_item, select;
    logic coin_10_p, coin_25_p, next_item_p, select_p;
    logic [3:0] outs_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] ins;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_10     (coin_10),
        .coin_25     (coin_25),
        .next_item   (next_item),
        .select      (select),
        .coin_10_p   (coin_10_p),
        .coin_25_p   (coin_25_p),
        .next_item_p (next_item_p),
        .select_p    (select_p)
    );

    assign outs_s = {coin_10_p, coin_25_p, next_item_p, select_p};

    always #5 clk = ~clk;

    task automatic push(input int n, input logic [3:0] ins, input logic [3:0] exp);
        vec_t v;
        v.ins = ins;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] ins);
        {coin_10, coin_25, next_item, select} = ins;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        n_cmp++;
        if (outs_s !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs=%b expected=%b (t=%0t)", name, outs_s, exp, $time);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(NONE);
        #12;
        check("reset_state", NONE);
        step();
        step();
        reset = 1'b0;

        // Idle so every lane arms.
        push(6, NONE, NONE);
        // Clean coin_10 press: pulse on the 6th edge after driving.
        push(5, C10, NONE);
        push(1, C10, C10);
        push(4, C10, NONE);
        push(10, NONE, NONE);
        // Simultaneous coins: coin_25 first, coin_10 the next cycle.
        push(5, C10 | C25, NONE);
        push(1, C10 | C25, C25);
        push(1, C10 | C25, C10);
        push(3, C10 | C25, NONE);
        push(10, NONE, NONE);
        // Simultaneous buttons: select only, next_item dropped.
        push(5, NXT | SEL, NONE);
        push(1, NXT | SEL, SEL);
        push(4, NXT | SEL, NONE);
        push(10, NONE, NONE);
        // Select bounce: 3 high, 1 low, then steady high.
        push(3, SEL, NONE);
        push(1, NONE, NONE);
        push(5, SEL, NONE);
        push(1, SEL, SEL);
        push(4, SEL, NONE);
        push(10, NONE, NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ins);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset while coin_10 is pending: both pulses in flight are lost.
        drive(C10 | C25);
        for (int i = 0; i < 5; i++) begin
            step();
            check("pend_pre", NONE);
        end
        step();
        check("pend_c25", C25);
        reset = 1'b1;
        #1;
        check("pend_async_rst", NONE);
        drive(NONE);
        step();
        check("pend_in_rst", NONE);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("pend_lost", NONE);
        end

        // Reset two cycles into a coin_25 debounce, coin_25 held afterwards.
        drive(C25);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_async", NONE);
        step();
        check("mid_rst_hold", NONE);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("mid_rst_no_c25", NONE);
        end
        drive(NONE);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mid_rst_release", NONE);
        end

        // next_item held through reset: no pulse until released and re-pressed.
        drive(NXT);
        step();
        step();
        reset = 1'b1;
        step();
        step();
        check("held_in_rst", NONE);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("held_no_pulse", NONE);
        end
        drive(NONE);
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_release", NONE);
        end
        drive(NXT);
        for (int i = 0; i < 5; i++) begin
            step();
            check("repress_wait", NONE);
        end
        step();
        check("repress_pulse", NXT);
        step();
        check("repress_one_cycle", NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_input_conditioner
